// File: rtl/fifo_top_sync.sv
// Single-clock 16x8 FIFO with pad-level ports. Pad cells are transparent, so the
// pins connect straight into the core.
module fifo_top_sync #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk_pad,
  input  logic                 rst_pad,
  input  logic                 wr_en_pad,
  input  logic [DATA_SIZE-1:0] wr_data_pad,
  input  logic                 rd_en_pad,
  output logic [DATA_SIZE-1:0] rd_data_pad,
  output logic                 full_pad,
  output logic                 empty_pad
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 wr_acc, rd_acc;
  logic                 full, empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]) &&
                 (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);

  assign wr_acc = wr_en_pad && !full;
  assign rd_acc = rd_en_pad && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + (ADDR_SIZE+1)'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + (ADDR_SIZE+1)'(1);
      rd_data_d = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
    end
  end

  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is never cleared; a reset simply discards it by rewinding the pointers.
  always_ff @(posedge clk_pad) begin
    if (!rst_pad && wr_acc) begin
      mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= wr_data_pad;
    end
  end

  assign rd_data_pad = rd_data_q;
  assign full_pad    = full;
  assign empty_pad   = empty;

endmodule

// File: tb/tb_fifo_top_sync.sv
// Bench for fifo_top_sync: directed boundary cases plus random traffic, all
// checked against a queue-based model of the FIFO.
module tb_fifo_top_sync;

  logic       clk_pad = 1'b0;
  logic       rst_pad = 1'b1;
  logic       wr_en_pad = 1'b0;
  logic [7:0] wr_data_pad = 8'h00;
  logic       rd_en_pad = 1'b0;
  logic [7:0] rd_data_pad;
  logic       full_pad;
  logic       empty_pad;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_rdd = 8'h00;

  fifo_top_sync #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
    .clk_pad     (clk_pad),
    .rst_pad     (rst_pad),
    .wr_en_pad   (wr_en_pad),
    .wr_data_pad (wr_data_pad),
    .rd_en_pad   (rd_en_pad),
    .rd_data_pad (rd_data_pad),
    .full_pad    (full_pad),
    .empty_pad   (empty_pad)
  );

  always #5 clk_pad = ~clk_pad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [7:0] d);
    int occ;
    @(negedge clk_pad);
    rst_pad     = rst;
    wr_en_pad   = wr;
    rd_en_pad   = rd;
    wr_data_pad = d;
    occ = m_q.size();
    if (rst) begin
      m_q.delete();
      m_rdd = 8'h00;
    end else begin
      if (rd && occ != 0) m_rdd = m_q.pop_front();
      if (wr && occ != 16) m_q.push_back(d);
    end
    @(posedge clk_pad);
    #1;
    chk("rd_data", 32'(rd_data_pad), 32'(m_rdd));
    chk("full", 32'(full_pad), 32'(m_q.size() == 16));
    chk("empty", 32'(empty_pad), 32'(m_q.size() == 0));
  endtask

  initial begin
    logic [7:0] d;
    logic       w, r;

    // Reset held two edges with both requests active
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("rst_empty", 32'(empty_pad), 32'd1);
    chk("rst_full", 32'(full_pad), 32'd0);
    chk("rst_rdata", 32'(rd_data_pad), 32'h00);

    // Fill 0x01..0x10, then an ignored write
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(full_pad), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("over_full", 32'(full_pad), 32'd1);

    // Drain in order, then an ignored read
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_data", 32'(rd_data_pad), 32'(i));
    end
    chk("drain_empty", 32'(empty_pad), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("under_hold", 32'(rd_data_pad), 32'h10);

    // Simultaneous write+read while full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("full_wr_rd_data", 32'(rd_data_pad), 32'h20);
    chk("full_wr_rd_flag", 32'(full_pad), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("no_aa_last", 32'(rd_data_pad), 32'h2F);
    chk("no_aa_empty", 32'(empty_pad), 32'd1);

    // Simultaneous write+read while empty
    step(1'b0, 1'b1, 1'b1, 8'h55);
    chk("empty_wr_rd_hold", 32'(rd_data_pad), 32'h2F);
    chk("empty_wr_rd_flag", 32'(empty_pad), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("empty_wr_rd_stored", 32'(rd_data_pad), 32'h55);

    // Streaming across pointer wraps with one word preloaded
    step(1'b0, 1'b1, 1'b0, 8'(($urandom)));
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'($urandom));
      chk("stream_nofull", 32'(full_pad), 32'd0);
      chk("stream_noempty", 32'(empty_pad), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Random traffic: write-heavy then read-heavy to reach both boundaries
    for (int i = 0; i < 1000; i++) begin
      if (i < 500) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 4);
      end else begin
        w = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      d = 8'($urandom);
      step(1'b0, w, r, d);
    end

    // Reset in the middle of a stream
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("mid_pre_empty", 32'(empty_pad), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("mid_rst_empty", 32'(empty_pad), 32'd1);
    chk("mid_rst_rdata", 32'(rd_data_pad), 32'h00);
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("mid_read_3c", 32'(rd_data_pad), 32'h3C);
    chk("mid_end_empty", 32'(empty_pad), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
